bram_stream_reader: RTL and testbench

- Read-side master for the team's dual-port BRAM.
- Drives one BRAM port (address, enable, output-register enable) to read a contiguous, wrap-around address range.
- Absorbs the fixed BRAM read latency and presents the words as a valid/ready stream with a last marker.
- Sits between frame/coefficient buffers and downstream pipelines that may stall.

---
 rtl/bram_stream_reader.sv | 201 ++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a contiguous, wrap-around address range from one
// BRAM port and presents the words as a valid/ready stream with a last marker.
// The fixed BRAM read latency is tracked by a small shift register. A
// first-word-fall-through skid FIFO sits on the output. Reads are only issued
// when the FIFO is guaranteed to have room for them, so a stalled consumer
// never causes data to be lost.
module bram_stream_reader #(
   parameter  int RAM_WIDTH    = 18,
   parameter  int RAM_DEPTH    = 1024,
   parameter  int READ_LATENCY = 2,
   parameter  int FIFO_DEPTH   = 4,
   localparam int ADDR_W       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic                 clka,
   input  logic                 rsta,
   input  logic                 start_in,
   input  logic [ADDR_W-1:0]    base_addr_in,
   input  logic [ADDR_W:0]      length_in,
   output logic [ADDR_W-1:0]    ram_addr_out,
   output logic                 ram_en_out,
   output logic                 ram_regce_out,
   output logic                 ram_we_out,
   input  logic [RAM_WIDTH-1:0] ram_data_in,
   output logic [RAM_WIDTH-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 last_out,
   output logic                 busy_out,
   output logic                 done_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // Wide enough to hold outstanding reads plus FIFO occupancy without wrapping
   localparam int CNT_W = PTR_W + 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   if (READ_LATENCY < 1 || FIFO_DEPTH < READ_LATENCY + 1 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("bram_stream_reader: FIFO_DEPTH must be a power of two >= READ_LATENCY+1");
   end

   logic [1:0]             state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ADDR_W:0]        remaining_q, remaining_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [READ_LATENCY-1:0] lat_vld_q, lat_vld_d;
   logic [READ_LATENCY-1:0] lat_last_q, lat_last_d;
   logic [RAM_WIDTH:0]     fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         count_q, count_d;

   logic [CNT_W-1:0]       outstanding;
   logic [CNT_W-1:0]       credit_used;
   logic                   issue, issue_last;
   logic                   push, pop;
   logic                   fifo_empty, fifo_full;
   logic [RAM_WIDTH:0]     head;

   // Count reads in flight and combine with FIFO occupancy to decide whether another read fits
   always_comb begin
      outstanding = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         outstanding = outstanding + CNT_W'(lat_vld_q[i]);
      end
      credit_used = outstanding + CNT_W'(count_q);
   end

   // Burst sequencing: accept a start, issue one read per cycle while credit allows, wait for the final handshake
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      issue_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               if (length_in != '0) begin
                  addr_d      = base_addr_in;
                  remaining_d = length_in;
                  busy_d      = 1'b1;
                  state_d     = S_ISSUE;
               end else begin
                  // Zero-length request completes immediately without touching the BRAM
                  done_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (credit_used < CNT_W'(FIFO_DEPTH)) begin
               issue       = 1'b1;
               issue_last  = (remaining_q == (ADDR_W+1)'(1));
               remaining_d = remaining_q - (ADDR_W+1)'(1);
               // Compare-based wrap so non-power-of-two depths stay in range
               addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
               if (issue_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head[RAM_WIDTH]) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Shift the per-read {valid,last} tags so they line up with the BRAM data
   always_comb begin
      lat_vld_d[0]  = issue;
      lat_last_d[0] = issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
         lat_vld_d[i]  = lat_vld_q[i-1];
         lat_last_d[i] = lat_last_q[i-1];
      end
   end

   // Skid FIFO bookkeeping: push when a tagged read lands, pop on an output handshake
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
      push       = lat_vld_q[READ_LATENCY-1];
      pop        = !fifo_empty && ready_in;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset aborts any burst and discards everything in flight
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lat_vld_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         lat_vld_q   <= lat_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Data-only storage: last tags and FIFO entries are qualified by the control state above
   always_ff @(posedge clka) begin
      lat_last_q <= lat_last_d;
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {lat_last_q[READ_LATENCY-1], ram_data_in};
      end
   end

   // Overflow must be unreachable given the credit check on issue
   always_ff @(posedge clka) begin
      if (!rsta) begin
         assert (!(push && !pop && fifo_full));
      end
   end

   always_comb begin
      head          = fifo_mem_q[rd_ptr_q];
      ram_addr_out  = addr_q;
      ram_en_out    = issue;
      ram_regce_out = 1'b1;
      ram_we_out    = 1'b0;
      valid_out     = !fifo_empty;
      data_out      = fifo_empty ? '0 : head[RAM_WIDTH-1:0];
      last_out      = !fifo_empty && head[RAM_WIDTH];
      busy_out      = busy_q;
      done_out      = done_q;
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: behavioural BRAM, queue-based reference
// of the expected address/data/last sequence, randomized bursts and ready patterns.
module tb_bram_stream_reader;

   localparam int RAM_WIDTH    = 18;
   localparam int RAM_DEPTH    = 1024;
   localparam int READ_LATENCY = 2;
   localparam int FIFO_DEPTH   = 4;
   localparam int ADDR_W       = 10;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start_in;
   logic [ADDR_W-1:0]    base_addr_in;
   logic [ADDR_W:0]      length_in;
   logic [ADDR_W-1:0]    ram_addr_out;
   logic                 ram_en_out, ram_regce_out, ram_we_out;
   logic [RAM_WIDTH-1:0] ram_data_in;
   logic [RAM_WIDTH-1:0] data_out;
   logic                 valid_out, last_out, busy_out, done_out;
   logic                 ready_in = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ready_mode = 0;
   bit mon_en   = 1'b0;

   // Reference state
   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] exp_data [$];
   bit                   exp_last [$];
   int                   exp_addr [$];
   int issued_cnt = 0, popped_cnt = 0, en_total = 0, hs_cnt = 0;
   int last_hs_cyc = -1, first_valid_cyc = -1;

   bram_stream_reader #(
      .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH),
      .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clka(clk), .rsta(rst), .start_in(start_in), .base_addr_in(base_addr_in),
      .length_in(length_in), .ram_addr_out(ram_addr_out), .ram_en_out(ram_en_out),
      .ram_regce_out(ram_regce_out), .ram_we_out(ram_we_out), .ram_data_in(ram_data_in),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
      .last_out(last_out), .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: first stage captures on enable, later stages follow regce
   logic [RAM_WIDTH-1:0] bram_pipe [READ_LATENCY];
   always @(posedge clk) begin
      if (ram_en_out) bram_pipe[0] <= mem[ram_addr_out];
      for (int i = 1; i < READ_LATENCY; i++)
         if (ram_regce_out) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign ram_data_in = bram_pipe[READ_LATENCY-1];

   // Ready patterns: 0 = always, 1 = 1,0,0,1 repeating, 2 = random ~70%
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         2:       ready_in = ($urandom % 10) < 7;
         default: ready_in = 1'b1;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Stream monitor: addresses, credit limit and output words against the reference queues
   always @(negedge clk) begin
      if (rst) begin
         issued_cnt = 0;
         popped_cnt = 0;
      end else begin
         if (ram_en_out) begin
            check("credit_limit", 32'((issued_cnt - popped_cnt) < FIFO_DEPTH), 32'd1);
            check("issue_expected", 32'(mon_en && exp_addr.size() != 0), 32'd1);
            if (mon_en && exp_addr.size() != 0)
               check("ram_addr", 32'(ram_addr_out), 32'(exp_addr.pop_front()));
            issued_cnt++;
            en_total++;
         end
         if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (valid_out && ready_in) begin
            check("word_expected", 32'(mon_en && exp_data.size() != 0), 32'd1);
            if (mon_en && exp_data.size() != 0) begin
               check("data", 32'(data_out), 32'(exp_data.pop_front()));
               check("last", 32'(last_out), 32'(exp_last.pop_front()));
            end
            popped_cnt++;
            hs_cnt++;
            last_hs_cyc = cyc;
         end
      end
   end

   task automatic prep(input int base, input int len);
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      for (int k = 0; k < len; k++) begin
         exp_addr.push_back((base + k) % RAM_DEPTH);
         exp_data.push_back(mem[(base + k) % RAM_DEPTH]);
         exp_last.push_back(k == len - 1);
      end
      first_valid_cyc = -1;
      mon_en = 1'b1;
   endtask

   // One burst; optional second start at loop cycle restart_at must be ignored
   task automatic run_burst(input int base, input int len, input int rmode, input int restart_at);
      int start_cyc, cnt, en_before;
      prep(base, len);
      ready_mode = rmode;
      en_before = en_total;
      base_addr_in = ADDR_W'(base);
      length_in = (ADDR_W+1)'(len);
      start_in = 1'b1;
      start_cyc = cyc;
      tick;
      start_in = 1'b0;
      if (len == 0) begin
         check("len0_done", 32'(done_out), 32'd1);
         check("len0_busy", 32'(busy_out), 32'd0);
         for (int i = 0; i < 3; i++) begin
            tick;
            check("len0_valid", 32'(valid_out), 32'd0);
            check("len0_done_once", 32'(done_out), 32'd0);
         end
         check("len0_no_issue", 32'(en_total - en_before), 32'd0);
      end else begin
         check("busy_set", 32'(busy_out), 32'd1);
         cnt = 0;
         while (!done_out && cnt < 5000) begin
            if (cnt == restart_at) begin
               base_addr_in = ADDR_W'((base + 300) % RAM_DEPTH);
               length_in = (ADDR_W+1)'(3);
               start_in = 1'b1;
            end else begin
               start_in = 1'b0;
            end
            tick;
            cnt++;
         end
         start_in = 1'b0;
         check("done_seen", 32'(done_out), 32'd1);
         check("busy_clear", 32'(busy_out), 32'd0);
         check("done_after_last", 32'(cyc), 32'(last_hs_cyc + 1));
         check("words_left", 32'(exp_data.size()), 32'd0);
         check("addrs_left", 32'(exp_addr.size()), 32'd0);
         // edges after the one sampling start_in, up to the edge raising valid_out
         check("first_valid_lat", 32'(first_valid_cyc - (start_cyc + 1)), 32'(READ_LATENCY + 1));
         tick;
         check("done_one_cycle", 32'(done_out), 32'd0);
         check("idle_valid", 32'(valid_out), 32'd0);
      end
      mon_en = 1'b0;
   endtask

   initial begin
      int cnt, hs_before, b, l;
      rst = 1'b1; start_in = 1'b0; base_addr_in = '0; length_in = '0;
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'(i);
      repeat (3) tick;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_done", 32'(done_out), 32'd0);
      check("rst_en", 32'(ram_en_out), 32'd0);
      check("rst_last", 32'(last_out), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_regce", 32'(ram_regce_out), 32'd1);
      check("rst_we", 32'(ram_we_out), 32'd0);
      rst = 1'b0;
      repeat (2) tick;

      run_burst(5, 8, 0, -1);
      run_burst(1021, 6, 0, -1);
      run_burst(0, 16, 1, -1);
      run_burst(0, 0, 0, -1);
      run_burst(7, 1, 0, -1);
      run_burst(40, 12, 1, 4);
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'($urandom);
      run_burst(300, 1024, 0, -1);

      // Reset in the middle of a burst
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'(i);
      prep(200, 20);
      ready_mode = 0;
      base_addr_in = ADDR_W'(200); length_in = (ADDR_W+1)'(20); start_in = 1'b1;
      tick;
      start_in = 1'b0;
      hs_before = hs_cnt; cnt = 0;
      while ((hs_cnt - hs_before) < 7 && cnt < 100) begin tick; cnt++; end
      check("rst_mid_accepted", 32'(hs_cnt - hs_before), 32'd7);
      rst = 1'b1; mon_en = 1'b0;
      tick;
      rst = 1'b0;
      check("rst_mid_valid", 32'(valid_out), 32'd0);
      check("rst_mid_busy", 32'(busy_out), 32'd0);
      check("rst_mid_done", 32'(done_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick;
         check("rst_mid_no_done", 32'(done_out), 32'd0);
         check("rst_mid_idle", 32'(valid_out), 32'd0);
      end
      run_burst(100, 2, 0, -1);

      // Randomized bursts
      for (int i = 0; i < 10; i++) begin
         b = $urandom % RAM_DEPTH;
         l = $urandom_range(1, 40);
         for (int j = 0; j < RAM_DEPTH; j++) mem[j] = RAM_WIDTH'($urandom);
         run_burst(b, l, $urandom % 3, ((i % 3) == 0) ? 2 : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
